// File: rtl/musicbox_audio_pkg.sv
// musicbox_audio_pkg: shared sample type, DAC midscale code and feeder FSM encoding.
package musicbox_audio_pkg;
    localparam int SAMPLE_W = 12;
    localparam logic [SAMPLE_W-1:0] DAC_MIDSCALE = 12'h800;
    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef enum logic [1:0] {FS_IDLE, FS_REQ, FS_BUSY, FS_DONE} feeder_state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-two sample buffer with show-ahead read data and a level count.
module sample_fifo
    import musicbox_audio_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic w_wr;
    logic w_rd;
    assign o_full = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_rd = i_rd_en && !o_empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign w_wr = i_wr_en && (!o_full || w_rd);
    always_ff @(posedge i_clk)
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + LW'(w_wr) - LW'(w_rd);
        end
    end
endmodule

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: paces buffered samples into an SPI DAC controller at SAMPLE_DIV clocks per sample.
// Define DAC_SAMPLE_FEEDER_STATS_EN to add saturating underrun/missed-tick counters.
module dac_sample_feeder
    import musicbox_audio_pkg::*;
#(
    parameter int SAMPLE_DIV  = 3125,
    parameter int FIFO_DEPTH  = 8,
    parameter int REQ_TIMEOUT = 64
) (
    input  logic                          clock_50Mhz,
    input  logic                          reset_n,
    input  logic [SAMPLE_W-1:0]           in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [SAMPLE_W-1:0]           dac_sample,
    output logic                          dac_send_n,
    input  logic                          dac_isBusy,
    input  logic                          dac_transmitComplete,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          tick_missed,
`ifdef DAC_SAMPLE_FEEDER_STATS_EN
    output logic                          dac_fault,
    output logic [15:0]                   underrun_count,
    output logic [15:0]                   missed_count
`else
    output logic                          dac_fault
`endif
);
    localparam int CW = $clog2(SAMPLE_DIV + 1);
    localparam int TW = $clog2(REQ_TIMEOUT + 1);
    feeder_state_t r_state;
    feeder_state_t w_state_nxt;
    logic [CW-1:0] r_tick_cnt;
    logic [TW-1:0] r_req_cnt;
    sample_t r_sample;
    sample_t w_head;
    logic r_underrun;
    logic r_missed;
    logic r_fault;
    logic w_tick;
    logic w_idle;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_underrun;
    logic w_missed;
    logic w_timeout;
    assign w_tick = r_tick_cnt == CW'(SAMPLE_DIV - 1);
    assign w_idle = r_state == FS_IDLE;
    assign w_pop = w_tick && w_idle && !w_empty;
    assign w_underrun = w_tick && w_idle && w_empty;
    assign w_missed = w_tick && !w_idle;
    assign w_timeout = r_req_cnt == TW'(REQ_TIMEOUT - 1);
    assign in_ready = !w_full || w_pop;
    assign dac_sample = r_sample;
    assign dac_send_n = r_state != FS_REQ;
    assign underrun = r_underrun;
    assign tick_missed = r_missed;
    assign dac_fault = r_fault;
    sample_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (clock_50Mhz),
        .i_rst_n   (reset_n),
        .i_wr_en   (in_valid),
        .i_wr_data (in_sample),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );
    // Busy wins over completion in REQ; the timeout only fires if neither arrived.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FS_IDLE: w_state_nxt = w_tick ? FS_REQ : FS_IDLE;
            FS_REQ:  w_state_nxt = dac_isBusy ? FS_BUSY : dac_transmitComplete ? FS_DONE : w_timeout ? FS_IDLE : FS_REQ;
            FS_BUSY: w_state_nxt = dac_transmitComplete ? FS_DONE : FS_BUSY;
            default: w_state_nxt = FS_IDLE;
        endcase
    end
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FS_IDLE;
            r_tick_cnt <= '0;
            r_req_cnt <= '0;
            r_sample <= DAC_MIDSCALE;
            r_underrun <= 1'b0;
            r_missed <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);
            r_req_cnt <= (r_state == FS_REQ) ? r_req_cnt + TW'(1) : '0;
            if (w_pop) r_sample <= w_head;
            r_underrun <= w_underrun;
            r_missed <= w_missed;
            r_fault <= r_state == FS_REQ && !dac_isBusy && !dac_transmitComplete && w_timeout;
        end
    end
`ifdef DAC_SAMPLE_FEEDER_STATS_EN
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count <= '0;
            missed_count <= '0;
        end else begin
            if (w_underrun && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
            if (w_missed && missed_count != 16'hFFFF) missed_count <= missed_count + 16'd1;
        end
    end
`else
`endif
endmodule

// File: doc/dac_sample_feeder.md
DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 Parameter SAMPLE_DIV, default 3125, is the number of clock_50Mhz cycles per output sample period (16 kHz at 50 MHz).
REQ-002 Parameter FIFO_DEPTH, default 8, is the sample buffer depth; legal values are powers of two from 2 to 64.
REQ-003 Parameter REQ_TIMEOUT, default 64, is the maximum number of cycles to wait for the DAC to report busy.
REQ-004 clock_50Mhz  in  1  is the single system clock; every flop is on its rising edge.
REQ-005 reset_n  in  1  is the asynchronous, active-low reset.
REQ-006 in_sample  in  12  is the unsigned upstream sample.
REQ-007 in_valid  in  1  indicates that in_sample is presented.
REQ-008 in_ready  out  1  is high when the FIFO can accept a write; a write occurs when in_valid && in_ready.
REQ-009 dac_sample  out  12  is the sample held for the SPI DAC controller's inputSample.
REQ-010 dac_send_n  out  1  is the active-low send request to the SPI DAC controller's sendSample_n.
REQ-011 dac_isBusy  in  1  is the busy flag from the SPI DAC controller.
REQ-012 dac_transmitComplete  in  1  is the single-cycle completion pulse from the SPI DAC controller.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  is the current FIFO occupancy.
REQ-014 underrun  out  1  is a one-cycle pulse when a sample tick finds the FIFO empty.
REQ-015 tick_missed  out  1  is a one-cycle pulse when a sample tick arrives while the FSM is not in IDLE.
REQ-016 dac_fault  out  1  is a one-cycle pulse when a request times out.

Function
REQ-017 The tick counter shall count 0..SAMPLE_DIV-1, wrap to 0, and assert the internal tick for one cycle at terminal count.
REQ-018 The FIFO shall store up to FIFO_DEPTH samples; in_ready=0 when full, and a write while full shall be ignored.
REQ-019 A simultaneous FIFO write and pop shall leave fifo_level unchanged, including when the FIFO is full; when the FIFO is empty, the write shall be stored and no pop occurs.
REQ-020 The FSM shall have the states IDLE, REQ, BUSY and DONE.
REQ-021 On a tick in IDLE with the FIFO non-empty, the FSM shall pop the head into dac_sample and go to REQ on the next cycle.
REQ-022 On a tick in IDLE with the FIFO empty, the FSM shall pulse underrun, keep dac_sample unchanged (the last sample is repeated) and go to REQ.
REQ-023 In REQ, dac_send_n shall be 0; on dac_isBusy=1 the FSM goes to BUSY, and dac_send_n returns to 1 in the same cycle as the transition.
REQ-024 In REQ, dac_transmitComplete=1 without a prior busy shall go directly to DONE.
REQ-025 If REQ lasts REQ_TIMEOUT cycles, the FSM shall pulse dac_fault, deassert dac_send_n and return to IDLE.
REQ-026 BUSY shall go to DONE on dac_transmitComplete=1; BUSY has no timeout.
REQ-027 DONE shall last exactly one cycle and then return to IDLE.
REQ-028 dac_sample shall change only on the IDLE-to-REQ transition, so it is stable throughout REQ, BUSY and DONE.
REQ-029 A tick in REQ, BUSY or DONE shall pulse tick_missed and be discarded; it shall not be queued.
REQ-030 Latency from tick to dac_send_n falling shall be exactly 1 cycle.

Reset
REQ-031 On reset_n=0 the FSM shall go to IDLE, the tick counter to 0, the FIFO pointers and fifo_level to 0, and dac_sample to 12'h800 (midscale).
REQ-032 On reset_n=0, dac_send_n shall be 1, underrun, tick_missed and dac_fault shall be 0, and in_ready shall be 1.
REQ-033 Reset asserted mid-transfer shall abort immediately with no further request; the block owns no SPI state.

Configuration
REQ-034 Macro DAC_SAMPLE_FEEDER_STATS_EN defined: the block shall add outputs underrun_count[15:0] and missed_count[15:0], saturating at 16'hFFFF and cleared by reset.
REQ-035 Macro DAC_SAMPLE_FEEDER_STATS_EN undefined: the count ports and their logic shall be absent, and all other behaviour shall be identical.

Structure
REQ-036 Package musicbox_audio_pkg shall hold SAMPLE_W=12, DAC_MIDSCALE=12'h800, the typedef sample_t (logic [11:0]) and the feeder FSM state enum.
REQ-037 The FIFO shall be the sub-module sample_fifo (parameterised width/depth, synchronous write/read, async reset); the tick counter and FSM shall be local to dac_sample_feeder.

Verification
REQ-038 Reset, no writes, SAMPLE_DIV=10 -> first tick: underrun=1, dac_sample=12'h800, dac_send_n=0 one cycle later.
REQ-039 Write 12'h123 and 12'h456, with a DAC model that sets busy 2 cycles after request and completes 20 cycles later -> dac_sample is 12'h123 and then 12'h456 on consecutive ticks, with no underrun.
REQ-040 Write 9 samples back-to-back with FIFO_DEPTH=8 and no ticks -> in_ready=0 after the 8th, the 9th is dropped, fifo_level=8.
REQ-041 DAC model holds busy for longer than SAMPLE_DIV -> tick_missed pulses, and the next sample is sent only after DONE.
REQ-042 DAC model never asserts busy -> dac_fault pulses at REQ_TIMEOUT=64 cycles, the FSM returns to IDLE, and the next tick retries.
REQ-043 Assert reset_n=0 while in BUSY with fifo_level=3 -> dac_send_n=1, fifo_level=0 and dac_sample=12'h800, all immediately and asynchronously.
